// File: rtl/pc_reg.sv
// pc_reg: program-counter register for the instruction-fetch stage.
// It loads the next instruction address from upstream next-PC logic on every
// rising clock edge. It does not increment, branch or stall.
//
// Ports:
//   clk_i  - system clock; the register loads on the rising edge
//   rst_i  - asynchronous reset, active-low; forces PC_o to RESET_VECTOR
//   PC_i   - next instruction address [ADDR_WIDTH-1:0], computed externally
//   PC_o   - current instruction address [ADDR_WIDTH-1:0], driven from pc_q
module pc_reg #(
    parameter int unsigned            ADDR_WIDTH   = 16,
    parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] PC_i,
    output logic [ADDR_WIDTH-1:0] PC_o
);

    // Asserted level of rst_i.
    localparam logic RST_ENABLE = 1'b0;

    logic [ADDR_WIDTH-1:0] pc_d;
    logic [ADDR_WIDTH-1:0] pc_q;

    // Next address is taken unmodified; wrap-around comes from upstream logic.
    always_comb begin
        pc_d = PC_i;
    end

    // The reset is asynchronous, so reset assertion takes effect mid-cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (rst_i == RST_ENABLE) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PC_o = pc_q;

endmodule

// File: tb/tb_pc_reg.sv
// tb_pc_reg: self-checking bench for pc_reg.
// It runs a table of directed vectors, hand sequences for the reset and
// mid-cycle corner cases, and a randomized run against a queue-based model.
module tb_pc_reg;

    localparam int unsigned   AW = 16;
    localparam logic [AW-1:0] RV = 16'h0000;

    logic          clk_i;
    logic          rst_i;
    logic [AW-1:0] PC_i;
    logic [AW-1:0] PC_o;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [AW-1:0] pc_in;
        logic [AW-1:0] exp;
    } vec_t;

    vec_t vecs[22];

    pc_reg #(
        .ADDR_WIDTH  (AW),
        .RESET_VECTOR(RV)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .PC_i (PC_i),
        .PC_o (PC_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: PC_o=%h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Call at a falling edge: drive, let one rising edge pass, check, return at the next falling edge.
    task automatic drive_check(input string name, input logic [AW-1:0] v, input logic [AW-1:0] exp);
        PC_i = v;
        @(posedge clk_i);
        #1;
        check(name, PC_o, exp);
        @(negedge clk_i);
    endtask

    initial begin
        logic [AW-1:0] exp_q[$];
        logic [AW-1:0] model_pc;
        logic [AW-1:0] v;

        n_checks = 0;
        n_fail   = 0;

        // Directed table: counting sequence, the extreme values, then a held value.
        for (int i = 0; i < 16; i++) begin
            vecs[i].pc_in = AW'(i + 1);
            vecs[i].exp   = AW'(i + 1);
        end
        vecs[16].pc_in = 16'hFFFF; vecs[16].exp = 16'hFFFF;
        vecs[17].pc_in = 16'h0000; vecs[17].exp = 16'h0000;
        for (int i = 18; i < 22; i++) begin
            vecs[i].pc_in = 16'h0040;
            vecs[i].exp   = 16'h0040;
        end

        // Reset takes effect before any clock edge.
        rst_i = 1'b1;
        PC_i  = 16'h00FF;
        #1 rst_i = 1'b0;
        #1 check("reset_async_initial", PC_o, RV);

        // Hold reset for 5 cycles while PC_i changes.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            PC_i = (c < 2) ? 16'h00FF : 16'h1234;
            @(posedge clk_i);
            #1 check("reset_hold", PC_o, RV);
        end
        @(negedge clk_i);
        PC_i = 'x;
        @(posedge clk_i);
        #1 check("reset_x_input", PC_o, RV);

        // Release reset between edges; no load happens until the next rising edge.
        @(negedge clk_i);
        PC_i  = 16'h0001;
        rst_i = 1'b1;
        #2 check("release_no_load", PC_o, RV);
        @(negedge clk_i);

        // Table-driven directed vectors.
        for (int i = 0; i < 16; i++) begin
            drive_check("count_seq", vecs[i].pc_in, vecs[i].exp);
        end

        // Assert reset while clk_i is high, 3 ns after a rising edge.
        PC_i = 16'h000A;
        @(posedge clk_i);
        #1 check("pre_mid_reset", PC_o, 16'h000A);
        #2 rst_i = 1'b0;
        #1 check("mid_cycle_reset", PC_o, RV);
        @(negedge clk_i);
        check("mid_cycle_reset_hold", PC_o, RV);
        PC_i = 16'h5555;
        @(posedge clk_i);
        #1 check("reset_ignores_edge", PC_o, RV);
        @(negedge clk_i);
        rst_i = 1'b1;
        drive_check("first_load_after_release", 16'h0BEE, 16'h0BEE);

        for (int i = 16; i < 22; i++) begin
            drive_check("table_vec", vecs[i].pc_in, vecs[i].exp);
        end

        // PC_i changes mid-cycle do not reach PC_o before the next edge.
        PC_i = 16'h1111;
        #2 check("midcycle_no_pass_1", PC_o, 16'h0040);
        PC_i = 16'h2222;
        #1 check("midcycle_no_pass_2", PC_o, 16'h0040);
        @(posedge clk_i);
        #1 check("midcycle_latest_loaded", PC_o, 16'h2222);
        #2 PC_i = 16'h3333;
        #1 check("midcycle_after_edge", PC_o, 16'h2222);
        @(negedge clk_i);

        // Randomized run: each driven value is queued and expected after the next edge.
        model_pc = 16'h2222;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                #2 rst_i = 1'b0;
                exp_q.delete();
                model_pc = RV;
                #1 check("rnd_reset_async", PC_o, model_pc);
                PC_i = AW'($urandom);
                @(posedge clk_i);
                #1 check("rnd_reset_hold", PC_o, model_pc);
                @(negedge clk_i);
                rst_i = 1'b1;
            end else begin
                case ($urandom_range(0, 9))
                    0:       v = '1;
                    1:       v = '0;
                    2:       v = model_pc + 1'b1;
                    default: v = AW'($urandom);
                endcase
                PC_i = v;
                exp_q.push_back(v);
                #2 check("rnd_stable_before_edge", PC_o, model_pc);
                @(posedge clk_i);
                model_pc = exp_q.pop_front();
                #1 check("rnd_load", PC_o, model_pc);
                @(negedge clk_i);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
